// File: rtl/halloween_pkg.sv
// halloween_pkg: opcodes, FSM states and colour encoding shared by the sequencer
package halloween_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DONE} state_t;
  typedef enum logic [1:0] {C_OFF, C_GREEN, C_PURPLE, C_ORANGE} color_t;
  localparam logic [3:0] OP_END       = 4'b0000;
  localparam logic [3:0] OP_RESTART   = 4'b0001;
  localparam logic [3:0] OP_GREEN     = 4'b0100;
  localparam logic [3:0] OP_PURPLE    = 4'b0101;
  localparam logic [3:0] OP_ORANGE    = 4'b0110;
  localparam logic [3:0] OP_SCREAM    = 4'b1000;
  localparam logic [3:0] OP_CACKLE    = 4'b1001;
  localparam logic [3:0] OP_BOO       = 4'b1010;
  localparam logic [3:0] OP_WAVEHANDS = 4'b1100;
  localparam logic [3:0] OP_MOVEJAW   = 4'b1101;
  localparam logic [3:0] OP_FOG       = 4'b1110;
  function automatic logic is_legal(logic [3:0] op);
    return op inside {OP_END, OP_RESTART, OP_GREEN, OP_PURPLE, OP_ORANGE, OP_SCREAM,
                      OP_CACKLE, OP_BOO, OP_WAVEHANDS, OP_MOVEJAW, OP_FOG};
  endfunction
  function automatic logic is_color(logic [3:0] op);
    return op inside {OP_GREEN, OP_PURPLE, OP_ORANGE};
  endfunction
  function automatic color_t color_of(logic [3:0] op);
    return op == OP_GREEN ? C_GREEN : op == OP_PURPLE ? C_PURPLE : op == OP_ORANGE ? C_ORANGE : C_OFF;
  endfunction
endpackage

// File: rtl/halloween_decode.sv
// halloween_decode: 4-bit opcode to 16-bit one-hot
module halloween_decode (
  input  logic [3:0]  code,
  output logic [15:0] onehot
);
  assign onehot = 16'd1 << code;
endmodule

// File: rtl/halloween_sequencer.sv
// halloween_sequencer: steps through a small opcode program, pulsing one event per
// executed slot, dwelling hold_cycles between steps and latching the light colour
module halloween_sequencer
  import halloween_pkg::*;
#(
  parameter int N_CH   = 4,
  parameter int HOLD_W = 8,
  parameter int PTR_W  = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              loop_en,
  input  logic [HOLD_W-1:0] hold_cycles,
  input  logic              prog_we,
  input  logic [PTR_W-1:0]  prog_addr,
  input  logic [3:0]        prog_data,
  output logic              evt_valid,
  output logic [3:0]        evt_code,
  output logic [15:0]       evt_onehot,
  output logic [1:0]        color,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [PTR_W-1:0]  ptr
);
  state_t state, nxt;
  logic [3:0] slot [N_CH];
  logic [HOLD_W-1:0] timer;
  logic [15:0] dec;
  logic [3:0] op;
  logic last, addr_ok, go, fetch, step, fin, kill;

  assign op = slot[ptr];
  assign last = ptr == PTR_W'(N_CH - 1);
  assign addr_ok = {1'b0, prog_addr} < (PTR_W + 1)'(N_CH);

  halloween_decode u_decode (.code(evt_code), .onehot(dec));
  assign evt_onehot = evt_valid ? dec : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_IDLE;
    else state <= nxt;

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:  nxt = start ? S_FETCH : S_IDLE;
      S_FETCH: nxt = op == OP_END ? S_DONE : op == OP_RESTART ? S_FETCH : S_HOLD;
      S_HOLD:  nxt = timer != '0 ? S_HOLD : (last && !loop_en) ? S_DONE : S_FETCH;
      default: nxt = S_IDLE;
    endcase
    if (abort) nxt = S_IDLE;
  end

  // abort outranks every strobe, including the event pulse of a pending fetch
  always_comb begin
    go    = state == S_IDLE && start && !abort;
    fetch = state == S_FETCH && !abort;
    step  = state == S_HOLD && timer == '0 && !abort;
    fin   = state == S_DONE && !abort;
    kill  = state != S_IDLE && abort;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      evt_valid <= 1'b0;
      evt_code  <= OP_END;
      color     <= C_OFF;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      ptr       <= '0;
      timer     <= '0;
      for (int i = 0; i < N_CH; i++) slot[i] <= OP_END;
    end else begin
      evt_valid <= fetch;
      done      <= fin;
      if (fetch) begin
        evt_code <= op;
        timer    <= hold_cycles;
      end else if (state == S_HOLD && timer != '0) timer <= timer - 1'b1;
      if (fetch && is_color(op)) color <= color_of(op);
      if (fetch && !is_legal(op)) err <= 1'b1;
      if (fetch && op == OP_RESTART) ptr <= '0;
      if (step) ptr <= last ? (loop_en ? '0 : ptr) : ptr + 1'b1;
      if (go) begin
        busy <= 1'b1;
        ptr  <= '0;
        err  <= 1'b0;
      end
      if (fin || kill) begin
        busy  <= 1'b0;
        color <= C_OFF;
      end
      if (kill) ptr <= '0;
      if (prog_we && !busy && addr_ok) slot[prog_addr] <= prog_data;
    end
endmodule
